regread_arbiter: RTL
====================

// Module: regread_arbiter
// PURPOSE
//  Shares one 32:1 x 32-bit register-file read port (5-bit select in, 32-bit data out) among NREQ requesters.
//  Requesters are the CPU debug path, the game/VGA logic and the score/HUD logic.
//  Round-robin arbitration; drives the read-mux select; registers the mux output; returns data to the winner.
//  Sits between the requesters and the register-file read mux. Grants one read per cycle.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  AW     5   register address width (32 registers)
//  DW     32  data width
// PORTS
//  clock       in   1         rising-edge clock
//  reset_n     in   1         asynchronous, active-low reset
//  req_valid   in   NREQ      requester i has a pending read
//  req_addr    in   NREQ*AW   register address; slice i = [i*AW +: AW]
//  req_ready   out  NREQ      one-hot grant; request i accepted when req_valid[i] & req_ready[i]
//  rf_busy     in   1         register file unavailable this cycle (write collision); no grant issued
//  rf_sel      out  AW        select to the read mux
//  rf_data     in   DW        read-mux output, combinational from rf_sel
//  resp_valid  out  NREQ      one-hot, 1-cycle pulse: resp_data belongs to requester i
//  resp_data   out  DW        registered read data
// BEHAVIOUR
//  - Reset (async, reset_n=0): req_ready=0, resp_valid=0, resp_data=0, rf_sel=0; rr_ptr=0; state=IDLE.
//  - Grant is combinational. It is the first i with req_valid[i], searching from rr_ptr upward with wrap-around.
//    No grant while rf_busy=1 or in reset. At most one req_ready bit is high.
//  - rf_sel = req_addr of the granted requester; it holds its last value when there is no grant.
//  - Latency is 1 cycle: if accepted in cycle N, then at the edge ending N resp_data<=rf_data and resp_valid<=onehot(i).
//    The response is visible in cycle N+1.
//  - resp_valid deasserts the next cycle unless a new grant occurred. Responses are not backpressured.
//  - Throughput: one read per cycle. Back-to-back grants to different requesters are allowed.
//  - rr_ptr <= (i+1) mod NREQ on each accepted grant; it is unchanged otherwise.
//  - FSM (2 states):
//      IDLE: no response pending.
//      RESP: response driven this cycle.
//    Transitions: IDLE->RESP on grant; RESP->RESP on grant; RESP->IDLE on no grant.
//  - Boundaries:
//      * All NREQ valid: each is served exactly once in NREQ cycles.
//      * rf_busy high with a pending request: no grant, rr_ptr frozen, requests held.
//      * Requester drops req_valid before its grant: it is simply skipped; no response.
//      * reset_n asserted mid-read: a pending response is discarded; outputs go to reset values immediately.
//      * Address 0 is read through the mux like any other address; the register file guarantees r0=0.
// CONFIGURATION
//  REGREAD_LOCK_EN defined:
//   - Adds input req_lock [NREQ].
//   - While the last granted requester g has req_valid[g] & req_lock[g]:
//       * rr_ptr stays at g, so g wins every cycle (burst read).
//       * Lock releases on the first cycle req_lock[g]=0; rr_ptr then advances normally.
//   - rf_busy still blocks the grant.
//  REGREAD_LOCK_EN undefined:
//   - No req_lock port; pure round-robin.
// STRUCTURE
//  - Shared package/header `regread_pkg`:
//      * FSM state encodings (ST_IDLE=1'b0, ST_RESP=1'b1).
//      * Default AW/DW constants, NREQ_MAX=8.
//  - One sub-module: rr_pick (NREQ-wide rotate-priority picker: valid vector + ptr -> one-hot grant).
//    Reused by other shared-resource arbiters.
//  - The read mux itself stays outside this block.
// TESTING
//  1. Reset: reset_n=0 with req_valid=4'b1111
//     -> req_ready=0, resp_valid=0, resp_data=0; reset release -> grant req 0 first.
//  2. Single read: req_valid=4'b0100, addr2=5'd7, reg7=32'hDEAD_BEEF
//     -> req_ready=4'b0100, rf_sel=7; next cycle resp_valid=4'b0100, resp_data=32'hDEAD_BEEF.
//  3. Fairness: all 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each gets 2 responses.
//  4. Stall: 2 requests pending, rf_busy=1 for 3 cycles
//     -> no req_ready, rr_ptr unchanged; after release, grants resume in round-robin order.
//  5. Mid-op reset: grant in cycle N, reset_n=0 during N+1
//     -> resp_valid=0 immediately; no stale response after release.
//  6. (REGREAD_LOCK_EN) req 1 locked for 4 reads while req 3 valid
//     -> 4 consecutive grants to 1, then req 3 granted on the cycle after unlock.

Source files
------------

// File: rtl/regread_arbiter_pkg.sv
// regread_pkg: shared constants, FSM state encoding and a one-hot helper
// for the register-file read-port arbiter and its picker.
package regread_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREQ_MAX = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [2:0] onehot_idx(input logic [NREQ_MAX-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/regread_arbiter_if.sv
// Requester-side bus of the register-file read arbiter: request valid/addr,
// one-hot grant, and the one-cycle-later response.
// Optional burst lock (req_lock) exists only when REGREAD_LOCK_EN is defined.
interface regread_arbiter_if
  import regread_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
`ifdef REGREAD_LOCK_EN
  logic [NREQ-1:0]    req_lock;

  modport master (output req_valid, req_addr, req_lock,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_addr, req_lock,
                  output req_ready, resp_valid, resp_data);
`else
  modport master (output req_valid, req_addr,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_addr,
                  output req_ready, resp_valid, resp_data);
`endif

endinterface

// File: rtl/regread_arbiter_rr_pick.sv
// rr_pick: rotate-priority picker. Returns a one-hot grant for the first
// set bit of 'valid' found searching upward from 'ptr' with wrap-around.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found_s;
  logic [PW-1:0] idx_s;

  // Scan N positions starting at ptr; the first valid one wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = PW'((int'(ptr) + k) % N);
      if (!found_s && valid[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// regread_arbiter: shares one register-file read port among NREQ requesters.
// Combinational round-robin grant, read-mux select driven in the grant cycle,
// mux output registered and returned to the winner one cycle later.
// Build option: REGREAD_LOCK_EN adds a per-requester burst lock.
module regread_arbiter
  import regread_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  regread_arbiter_if.slave bus,
  input  logic          rf_busy,
  output logic [AW-1:0] rf_sel,
  input  logic [DW-1:0] rf_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   start_s;
  logic [PW-1:0]   gidx_s;
  logic [NREQ-1:0] pick_s;
  logic [NREQ-1:0] grant_s;
  logic [NREQ-1:0] resp_who_r;
  logic            any_grant_s;
  logic [AW-1:0]   sel_last_r;
  logic [AW-1:0]   sel_s;
  logic [DW-1:0]   resp_data_r;
  state_e          state_r;
  state_e          state_nxt_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef REGREAD_LOCK_EN
  logic lock_hold_r;
  logic lock_live_s;

  // While locked, rr_ptr sits on the last winner; once its lock drops, search resumes past it.
  always_comb begin
    lock_live_s = lock_hold_r & bus.req_valid[rr_ptr_r] & bus.req_lock[rr_ptr_r];
    if (lock_hold_r && !lock_live_s) begin
      start_s = ptr_inc(rr_ptr_r);
    end else begin
      start_s = rr_ptr_r;
    end
  end

  // Remember whether the most recent grant was taken with the lock held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_hold_r <= 1'b0;
    end else if (any_grant_s) begin
      lock_hold_r <= bus.req_lock[gidx_s];
    end else begin
      lock_hold_r <= lock_hold_r;
    end
  end
`else
  assign start_s = rr_ptr_r;
`endif

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (start_s),
    .grant (pick_s)
  );

  // Gate the pick with busy/reset and steer the mux select to the winner.
  always_comb begin
    if (rf_busy || !reset_n) begin
      grant_s = '0;
    end else begin
      grant_s = pick_s;
    end
    any_grant_s = |grant_s;
    gidx_s      = PW'(onehot_idx(NREQ_MAX'(grant_s)));
    if (any_grant_s) begin
      sel_s = bus.req_addr[gidx_s*AW +: AW];
    end else begin
      sel_s = sel_last_r;
    end
  end

  assign bus.req_ready = grant_s;
  assign rf_sel        = sel_s;

  // Capture read data, winner, last select and advance rr_ptr on each grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r    <= '0;
      resp_who_r  <= '0;
      resp_data_r <= '0;
      sel_last_r  <= '0;
    end else if (any_grant_s) begin
`ifdef REGREAD_LOCK_EN
      rr_ptr_r    <= bus.req_lock[gidx_s] ? gidx_s : ptr_inc(gidx_s);
`else
      rr_ptr_r    <= ptr_inc(gidx_s);
`endif
      resp_who_r  <= grant_s;
      resp_data_r <= rf_data;
      sel_last_r  <= sel_s;
    end else begin
      rr_ptr_r    <= rr_ptr_r;
      resp_who_r  <= resp_who_r;
      resp_data_r <= resp_data_r;
      sel_last_r  <= sel_last_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a grant this cycle means a response next cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: state_nxt_s = any_grant_s ? ST_RESP : ST_IDLE;
      ST_RESP: state_nxt_s = any_grant_s ? ST_RESP : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: the response pulse belongs to the requester granted last cycle.
  always_comb begin
    bus.resp_data = resp_data_r;
    case (state_r)
      ST_RESP: bus.resp_valid = resp_who_r;
      ST_IDLE: bus.resp_valid = '0;
      default: bus.resp_valid = '0;
    endcase
  end

endmodule
